// File: rtl/gray_pkg.sv
// Shared constants and the output quantiser for the grayscale stream pipeline.
package gray_pkg;

  localparam int COEF_WIDTH  = 8;
  localparam int FRAC_SHIFT  = 8;
  localparam int DEF_COEF_R  = 77;
  localparam int DEF_COEF_G  = 150;
  localparam int DEF_COEF_B  = 29;
  localparam int ROUND_CONST = 128;

  // Drops the fractional bits and clamps to the largest ch_width-bit sample.
  function automatic logic [31:0] gray_sat(input logic [31:0] acc, input int ch_width);
    logic [31:0] shifted;
    logic [31:0] max_val;
    shifted = acc >> FRAC_SHIFT;
    max_val = (32'd1 << ch_width) - 32'd1;
    return (shifted > max_val) ? max_val : shifted;
  endfunction

endpackage

// File: rtl/gray_elastic_stage.sv
// One valid/ready register slice; holds its payload while the consumer stalls.
module gray_elastic_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);

  // Loads when empty or when the current beat leaves this cycle.
  assign in_ready = !rst && (!out_valid || out_ready);

  // NOTE: registers use <= so every stage samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      // NOTE: payload is reset too because the output data must read 0 after reset.
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_last <= in_last;
      end
    end
  end

endmodule

// File: rtl/gray_stream_pipe.sv
// Elastic 3-stage RGB-to-gray stream converter, 1-4 pixels per beat.
// Define GRAY_ROUND_EN for round-half-up; truncation otherwise.
module gray_stream_pipe
  import gray_pkg::*;
#(
  parameter int CH_WIDTH     = 8,
  parameter int PIX_PER_BEAT = 1,
  parameter int COEF_R       = DEF_COEF_R,
  parameter int COEF_G       = DEF_COEF_G,
  parameter int COEF_B       = DEF_COEF_B
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [3*CH_WIDTH*PIX_PER_BEAT-1:0] s_tdata,
  input  logic                               s_tvalid,
  input  logic                               s_tlast,
  output logic                               s_tready,
  output logic [CH_WIDTH*PIX_PER_BEAT-1:0]   m_tdata,
  output logic                               m_tvalid,
  output logic                               m_tlast,
  input  logic                               m_tready,
  output logic [15:0]                        frame_count
);

  localparam int PIX_W  = 3 * CH_WIDTH;
  localparam int PROD_W = CH_WIDTH + COEF_WIDTH;
  localparam int ACC_W  = CH_WIDTH + 10;
  localparam int S1_W   = 3 * PROD_W * PIX_PER_BEAT;
  localparam int S2_W   = ACC_W * PIX_PER_BEAT;
  localparam int S3_W   = CH_WIDTH * PIX_PER_BEAT;

  if (COEF_R + COEF_G + COEF_B > 256) begin : g_bad_coef_sum
    $error("gray_stream_pipe: COEF_R+COEF_G+COEF_B exceeds 256");
  end
  if (COEF_R > 255 || COEF_G > 255 || COEF_B > 255 ||
      COEF_R < 0 || COEF_G < 0 || COEF_B < 0) begin : g_bad_coef
    $error("gray_stream_pipe: coefficients must be 8-bit unsigned");
  end
  if (PIX_PER_BEAT < 1 || PIX_PER_BEAT > 4) begin : g_bad_ppb
    $error("gray_stream_pipe: PIX_PER_BEAT must be 1..4");
  end
  if (CH_WIDTH < 1 || ACC_W > 32) begin : g_bad_width
    $error("gray_stream_pipe: CH_WIDTH must be 1..22");
  end

  logic [S1_W-1:0] prod_next, s1_data;
  logic [S2_W-1:0] acc_next,  s2_data;
  logic [S3_W-1:0] gray_next;
  logic            s1_valid, s1_last, s2_ready;
  logic            s2_valid, s2_last, s3_ready;
  logic            s3_valid;

  // Products per pixel packed as {R*cr, G*cg, B*cb}.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    prod_next = '0;
    for (int p = 0; p < PIX_PER_BEAT; p++) begin
      prod_next[(3*p+2)*PROD_W +: PROD_W] =
        PROD_W'(s_tdata[p*PIX_W + 2*CH_WIDTH +: CH_WIDTH]) * PROD_W'(COEF_R);
      prod_next[(3*p+1)*PROD_W +: PROD_W] =
        PROD_W'(s_tdata[p*PIX_W + CH_WIDTH +: CH_WIDTH]) * PROD_W'(COEF_G);
      prod_next[(3*p)*PROD_W +: PROD_W] =
        PROD_W'(s_tdata[p*PIX_W +: CH_WIDTH]) * PROD_W'(COEF_B);
    end
  end

  always_comb begin
    acc_next = '0;
    for (int p = 0; p < PIX_PER_BEAT; p++) begin
      acc_next[p*ACC_W +: ACC_W] = ACC_W'(s1_data[(3*p+2)*PROD_W +: PROD_W])
                                 + ACC_W'(s1_data[(3*p+1)*PROD_W +: PROD_W])
                                 + ACC_W'(s1_data[(3*p)*PROD_W +: PROD_W]);
`ifdef GRAY_ROUND_EN
      acc_next[p*ACC_W +: ACC_W] = acc_next[p*ACC_W +: ACC_W] + ACC_W'(ROUND_CONST);
`endif
    end
  end

  always_comb begin
    gray_next = '0;
    for (int p = 0; p < PIX_PER_BEAT; p++) begin
      gray_next[p*CH_WIDTH +: CH_WIDTH] =
        CH_WIDTH'(gray_sat(32'(s2_data[p*ACC_W +: ACC_W]), CH_WIDTH));
    end
  end

  gray_elastic_stage #(.WIDTH(S1_W)) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_tvalid),
    .in_data   (prod_next),
    .in_last   (s_tlast),
    .in_ready  (s_tready),
    .out_valid (s1_valid),
    .out_data  (s1_data),
    .out_last  (s1_last),
    .out_ready (s2_ready)
  );

  gray_elastic_stage #(.WIDTH(S2_W)) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_data   (acc_next),
    .in_last   (s1_last),
    .in_ready  (s2_ready),
    .out_valid (s2_valid),
    .out_data  (s2_data),
    .out_last  (s2_last),
    .out_ready (s3_ready)
  );

  gray_elastic_stage #(.WIDTH(S3_W)) u_stage3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s2_valid),
    .in_data   (gray_next),
    .in_last   (s2_last),
    .in_ready  (s3_ready),
    .out_valid (s3_valid),
    .out_data  (m_tdata),
    .out_last  (m_tlast),
    .out_ready (m_tready)
  );

  // Masked during reset so the downstream never sees a transfer on the reset edge.
  assign m_tvalid = s3_valid && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
    end else if (m_tvalid && m_tready && m_tlast) begin
      frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_gray_stream_pipe.sv
// Randomised bench for gray_stream_pipe against a plain-arithmetic luma model.
module tb_gray_stream_pipe;

  localparam int CH = 8;
  localparam int P  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [3*CH*P-1:0] s_tdata;
  logic            s_tvalid, s_tlast, s_tready;
  logic [CH*P-1:0] m_tdata;
  logic            m_tvalid, m_tlast, m_tready;
  logic [15:0]     frame_count;

  logic [23:0]     a_s_tdata;
  logic            a_s_tvalid, a_s_tready;
  logic            a_s_tlast = 1'b0;
  logic            a_m_tready = 1'b1;
  logic [7:0]      a_m_tdata;
  logic            a_m_tvalid, a_m_tlast;
  logic [15:0]     a_frame_count;

  always #5 clk = ~clk;

  gray_stream_pipe #(.CH_WIDTH(CH), .PIX_PER_BEAT(P)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .frame_count(frame_count)
  );

  gray_stream_pipe #(.CH_WIDTH(CH), .PIX_PER_BEAT(1)) dut_single (
    .clk(clk), .rst(rst),
    .s_tdata(a_s_tdata), .s_tvalid(a_s_tvalid), .s_tlast(a_s_tlast), .s_tready(a_s_tready),
    .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tlast(a_m_tlast), .m_tready(a_m_tready),
    .frame_count(a_frame_count)
  );

  typedef struct { logic [31:0] data; logic last; } beat_t;

  int          tests_run    = 0;
  int          tests_failed = 0;
  beat_t       exp_q[$];
  beat_t       obs_q[$];
  int          stable_errs  = 0;
  logic [15:0] exp_frames   = '0;
  bit          hold_pending = 0;
  logic [31:0] hold_data;
  logic        hold_last;
  int          cyc = 0;
  int          ready_mode = 1;   // 0: low until release_cyc, 1: high, 2: random
  int          release_cyc = 0;
  int          held_acc = 0;
  int          held_block = 0;
  int          stalls = 0;

  function automatic int gray_ref(input int r, input int g, input int b);
    int acc;
    acc = 77*r + 150*g + 29*b;
`ifdef GRAY_ROUND_EN
    acc = acc + 128;
`endif
    acc = acc / 256;
    return (acc > 255) ? 255 : acc;
  endfunction

  function automatic logic [31:0] beat_ref(input logic [95:0] d);
    logic [31:0] o;
    o = '0;
    for (int p = 0; p < 4; p++)
      o[p*8 +: 8] = 8'(gray_ref(int'(d[p*24+16 +: 8]), int'(d[p*24+8 +: 8]), int'(d[p*24 +: 8])));
    return o;
  endfunction

  function automatic logic [95:0] rand_pixels();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Scoreboard taps: values seen at the falling edge are those the next rising edge will use.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      obs_q.delete();
      exp_frames   = '0;
      hold_pending = 0;
    end else begin
      if (hold_pending && (m_tvalid !== 1'b1 || m_tdata !== hold_data || m_tlast !== hold_last))
        stable_errs++;
      if (s_tvalid && s_tready) begin
        exp_q.push_back('{beat_ref(s_tdata), s_tlast});
        if (s_tlast) exp_frames = exp_frames + 16'd1;
      end
      if (m_tvalid && m_tready) obs_q.push_back('{m_tdata, m_tlast});
      hold_pending = m_tvalid && !m_tready;
      hold_data    = m_tdata;
      hold_last    = m_tlast;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    case (ready_mode)
      0:       m_tready = (cyc >= release_cyc);
      1:       m_tready = 1'b1;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
    #1;
  endtask

  task automatic send_beat(input logic [95:0] d, input logic last, output bit ok);
    logic acc;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      acc = s_tready;
      if (!m_tready && acc)  held_acc++;
      if (!m_tready && !acc) held_block++;
      if (!acc) stalls++;
      step();
      if (acc) begin
        ok = 1;
        break;
      end
    end
    s_tvalid = 1'b0;
  endtask

  // Lets the pipe empty, then compares the recorded stream with the model.
  task automatic drain(output int bad);
    int n;
    ready_mode = 1;
    m_tready   = 1'b1;
    #1;
    for (int i = 0; i < 100 && (obs_q.size() < exp_q.size() || m_tvalid); i++) step();
    bad = (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size() : exp_q.size() - obs_q.size();
    n   = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
        bad++;
        $display("  beat %0d got %h/%b want %h/%b", i, obs_q[i].data, obs_q[i].last,
                 exp_q[i].data, exp_q[i].last);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b1; s_tlast = 1'b1; s_tdata = '1;
    a_s_tvalid = 1'b1; a_s_tdata = '1; m_tready = 1'b1;
    repeat (3) step();
    tests_run++;
    if (s_tready !== 1'b0 || a_s_tready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_s_tready: got %b/%b want 0/0", s_tready, a_s_tready);
    end
    tests_run++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%h want 0/0/0", m_tvalid, m_tlast, m_tdata);
    end
    tests_run++;
    if (frame_count !== 16'd0) begin
      tests_failed++; $display("FAIL reset_frame_count: got %0d want 0", frame_count);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; a_s_tvalid = 1'b0;
    rst = 1'b0;
    #1;
    tests_run++;
    if (s_tready !== 1'b1 || a_s_tready !== 1'b1) begin
      tests_failed++; $display("FAIL ready_after_reset: got %b/%b want 1/1", s_tready, a_s_tready);
    end
  endtask

  // One beat presented on both instances; m_tvalid must rise after the third edge
  // counting the accepting edge.
  task automatic test_latency();
    int rise, a_rise, bad;
    logic [7:0] a_seen;
    logic [7:0] want;
    want = 8'(gray_ref(24, 99, 174));
    rise = 0; a_rise = 0; a_seen = '0;
    ready_mode = 1;
    s_tdata  = {72'd0, 8'd24, 8'd99, 8'd174};
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    a_s_tdata  = {8'd24, 8'd99, 8'd174};
    a_s_tvalid = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      s_tvalid = 1'b0;
      a_s_tvalid = 1'b0;
      if (m_tvalid && rise == 0) rise = e;
      if (a_m_tvalid && a_rise == 0) begin a_rise = e; a_seen = a_m_tdata; end
    end
    tests_run++;
    if (rise !== 3 || a_rise !== 3) begin
      tests_failed++; $display("FAIL latency: got %0d/%0d edges want 3/3", rise, a_rise);
    end
    tests_run++;
    if (a_seen !== want) begin
      tests_failed++; $display("FAIL single_pixel_value: got %0d want %0d", a_seen, want);
    end
    drain(bad);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++; $display("FAIL latency_stream: got %0d bad beats want 0", bad);
    end
  endtask

  task automatic test_corner_lanes();
    logic [31:0] want;
    bit ok;
    int bad;
`ifdef GRAY_ROUND_EN
    want = {8'd0, 8'd255, 8'd77, 8'd85};
`else
    want = {8'd0, 8'd255, 8'd76, 8'd84};
`endif
    ready_mode = 0; release_cyc = cyc + 1000; m_tready = 1'b0;
    send_beat({8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0,
               8'd24, 8'd99, 8'd174}, 1'b0, ok);
    for (int i = 0; i < 10 && !m_tvalid; i++) step();
    tests_run++;
    if (!ok || m_tvalid !== 1'b1 || m_tdata !== want) begin
      tests_failed++;
      $display("FAIL corner_lanes: got v=%b d=%h want v=1 d=%h", m_tvalid, m_tdata, want);
    end
    drain(bad);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++; $display("FAIL corner_stream: got %0d bad beats want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad;
    ready_mode = 1; m_tready = 1'b1; stalls = 0;
    #1;
    for (int i = 0; i < 20; i++) send_beat(rand_pixels(), 1'($urandom_range(0, 1)), ok);
    tests_run++;
    if (stalls !== 0) begin
      tests_failed++; $display("FAIL throughput: got %0d stall cycles want 0", stalls);
    end
    drain(bad);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++; $display("FAIL back_to_back_stream: got %0d bad beats want 0", bad);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    ready_mode = 0; release_cyc = cyc + 5; m_tready = 1'b0;
    held_acc = 0; held_block = 0; stable_errs = 0;
    #1;
    for (int i = 0; i < 10; i++) send_beat(rand_pixels(), 1'(i == 4 || i == 9), ok);
    tests_run++;
    if (held_acc !== 3 || held_block !== 2) begin
      tests_failed++;
      $display("FAIL backpressure_fill: got accepted=%0d blocked=%0d want 3/2", held_acc, held_block);
    end
    drain(bad);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++; $display("FAIL backpressure_stream: got %0d bad beats want 0", bad);
    end
    tests_run++;
    if (stable_errs !== 0) begin
      tests_failed++; $display("FAIL stall_stability: got %0d changes want 0", stable_errs);
    end
  endtask

  task automatic test_frames();
    bit ok;
    int bad;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    ready_mode = 2;
    for (int f = 1; f <= 2; f++) begin
      for (int i = 0; i < 4; i++) send_beat(rand_pixels(), 1'(i == 3), ok);
      drain(bad);
      tests_run++;
      if (bad !== 0) begin
        tests_failed++; $display("FAIL frame%0d_stream: got %0d bad beats want 0", f, bad);
      end
      tests_run++;
      if (frame_count !== 16'(f)) begin
        tests_failed++; $display("FAIL frame_count_%0d: got %0d want %0d", f, frame_count, f);
      end
      ready_mode = 2;
    end
  endtask

  task automatic test_random_stress();
    bit ok;
    int bad;
    ready_mode = 2; stable_errs = 0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      send_beat(rand_pixels(), 1'($urandom_range(0, 4) == 0), ok);
    end
    drain(bad);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++; $display("FAIL random_stream: got %0d bad beats want 0", bad);
    end
    tests_run++;
    if (frame_count !== exp_frames) begin
      tests_failed++; $display("FAIL random_frame_count: got %0d want %0d", frame_count, exp_frames);
    end
    tests_run++;
    if (stable_errs !== 0) begin
      tests_failed++; $display("FAIL random_stability: got %0d changes want 0", stable_errs);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad, rise;
    logic [31:0] want;
    ready_mode = 0; release_cyc = cyc + 1000; m_tready = 1'b0;
    send_beat(rand_pixels(), 1'b1, ok);
    send_beat(rand_pixels(), 1'b1, ok);
    step();
    m_tready = 1'b1;
    rst = 1'b1;
    #1;
    tests_run++;
    if (m_tvalid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_edge_valid: got %b want 0", m_tvalid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    tests_run++;
    if (m_tvalid !== 1'b0 || frame_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_state: got v=%b fc=%0d want v=0 fc=0", m_tvalid, frame_count);
    end
    ready_mode = 1; m_tready = 1'b1;
    s_tdata = {24'd0, 24'd0, 8'd255, 8'd0, 8'd0, 8'd24, 8'd99, 8'd174};
    want    = beat_ref(s_tdata);
    s_tlast = 1'b0; s_tvalid = 1'b1;
    rise = 0;
    for (int e = 1; e <= 4 && rise == 0; e++) begin
      step();
      s_tvalid = 1'b0;
      if (m_tvalid) rise = e;
    end
    tests_run++;
    if (rise !== 3 || m_tdata !== want) begin
      tests_failed++;
      $display("FAIL after_reset_beat: got edge=%0d d=%h want edge=3 d=%h", rise, m_tdata, want);
    end
    drain(bad);
    tests_run++;
    if (bad !== 0 || frame_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL after_reset_stream: got bad=%0d fc=%0d want 0/0", bad, frame_count);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b1;
    a_s_tvalid = 1'b0; a_s_tdata = '0;
    rst = 1'b1;
    test_reset();
    test_latency();
    test_corner_lanes();
    test_back_to_back();
    test_backpressure();
    test_frames();
    test_random_stress();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
